// File: rtl/id_ex_stage.sv
// ============================================================================
// Module      : id_ex_stage
// Description : Decode register file, load-use hazard detect, ID/EX register.
//               Optional macro PERF_CNT_EN adds stall/flush event counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_d,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic [DATA_W-1:0] ImmD,
    input  logic              RegWriteD,
    input  logic              MemReadD,
    input  logic              MemWriteD,
    input  logic              ALUSrcD,
    input  logic [2:0]        ALUControlD,
    input  logic              RegwriteW,
    input  logic [REG_AW-1:0] RdW,
    input  logic [DATA_W-1:0] ResultW,
    input  logic              flush_e,
    output logic              validE,
    output logic [DATA_W-1:0] RD1E,
    output logic [DATA_W-1:0] RD2E,
    output logic [DATA_W-1:0] ImmE,
    output logic [REG_AW-1:0] Rs1E,
    output logic [REG_AW-1:0] Rs2E,
    output logic [REG_AW-1:0] RdE,
    output logic              RegWriteE,
    output logic              MemReadE,
    output logic              MemWriteE,
    output logic              ALUSrcE,
    output logic [2:0]        ALUControlE,
`ifdef PERF_CNT_EN
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt,
`endif
    output logic              stall_fd
);

    localparam int c_NREG = 1 << REG_AW;

    logic [DATA_W-1:0] r_regs [c_NREG];
    logic              w_wbActive;
    logic              w_bypass1;
    logic              w_bypass2;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic              w_hazardMatch;

    // r0 is never written, so it stays at its reset value of zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wbActive) begin
            r_regs[RdW] <= ResultW;
        end
    end

    assign w_wbActive = RegwriteW && (RdW != '0);
    assign w_bypass1  = w_wbActive && (RdW == Rs1D);
    assign w_bypass2  = w_wbActive && (RdW == Rs2D);

    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if (Rs1D != '0) begin
            w_rd1 = w_bypass1 ? ResultW : r_regs[Rs1D];
        end
        if (Rs2D != '0) begin
            w_rd2 = w_bypass2 ? ResultW : r_regs[Rs2D];
        end
    end

    assign w_hazardMatch = (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign stall_fd      = rst && valid_d && validE && MemReadE && w_hazardMatch && !flush_e;

    // Flush and load-use stall both leave an all-zero bubble in E
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            validE      <= 1'b0;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmE        <= '0;
            Rs1E        <= '0;
            Rs2E        <= '0;
            RdE         <= '0;
            RegWriteE   <= 1'b0;
            MemReadE    <= 1'b0;
            MemWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            ALUControlE <= '0;
        end else if (flush_e || stall_fd) begin
            validE      <= 1'b0;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmE        <= '0;
            Rs1E        <= '0;
            Rs2E        <= '0;
            RdE         <= '0;
            RegWriteE   <= 1'b0;
            MemReadE    <= 1'b0;
            MemWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            ALUControlE <= '0;
        end else begin
            validE      <= valid_d;
            RD1E        <= w_rd1;
            RD2E        <= w_rd2;
            ImmE        <= ImmD;
            Rs1E        <= Rs1D;
            Rs2E        <= Rs2D;
            RdE         <= RdD;
            RegWriteE   <= valid_d && RegWriteD;
            MemReadE    <= valid_d && MemReadD;
            MemWriteE   <= valid_d && MemWriteD;
            ALUSrcE     <= ALUSrcD;
            ALUControlE <= ALUControlD;
        end
    end

`ifdef PERF_CNT_EN
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_fd && (stall_cnt != c_CNT_MAX)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush_e && (flush_cnt != c_CNT_MAX)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Directed self-checking bench for id_ex_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_d;
    logic [REG_AW-1:0] Rs1D, Rs2D, RdD;
    logic [DATA_W-1:0] ImmD;
    logic              RegWriteD, MemReadD, MemWriteD, ALUSrcD;
    logic [2:0]        ALUControlD;
    logic              RegwriteW;
    logic [REG_AW-1:0] RdW;
    logic [DATA_W-1:0] ResultW;
    logic              flush_e;
    logic              validE;
    logic [DATA_W-1:0] RD1E, RD2E, ImmE;
    logic [REG_AW-1:0] Rs1E, Rs2E, RdE;
    logic              RegWriteE, MemReadE, MemWriteE, ALUSrcE;
    logic [2:0]        ALUControlE;
    logic              stall_fd;
`ifdef PERF_CNT_EN
    logic [15:0]       stall_cnt, flush_cnt;
`endif

    int nVec = 0;
    int nMis = 0;

    id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst(rst), .valid_d(valid_d),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ImmD(ImmD),
        .RegWriteD(RegWriteD), .MemReadD(MemReadD), .MemWriteD(MemWriteD),
        .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD),
        .RegwriteW(RegwriteW), .RdW(RdW), .ResultW(ResultW), .flush_e(flush_e),
        .validE(validE), .RD1E(RD1E), .RD2E(RD2E), .ImmE(ImmE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RegWriteE(RegWriteE), .MemReadE(MemReadE), .MemWriteE(MemWriteE),
        .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
`ifdef PERF_CNT_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .stall_fd(stall_fd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nMis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearD();
        valid_d = 1'b0; Rs1D = '0; Rs2D = '0; RdD = '0; ImmD = '0;
        RegWriteD = 1'b0; MemReadD = 1'b0; MemWriteD = 1'b0;
        ALUSrcD = 1'b0; ALUControlD = '0;
        RegwriteW = 1'b0; RdW = '0; ResultW = '0; flush_e = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        clearD();
        #3;
        check("rst_validE", {31'd0, validE}, 32'd0);
        check("rst_RD1E", {16'd0, RD1E}, 32'd0);
        check("rst_stall", {31'd0, stall_fd}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // write-through of r3 into the same-cycle read
        valid_d = 1'b1; Rs1D = 3'd3; RdD = 3'd5; ImmD = 16'h00AB;
        RegWriteD = 1'b1; ALUSrcD = 1'b1; ALUControlD = 3'b101;
        RegwriteW = 1'b1; RdW = 3'd3; ResultW = 16'h1234;
        tick();
        check("wt_RD1E", {16'd0, RD1E}, 32'h1234);
        check("wt_validE", {31'd0, validE}, 32'd1);
        check("wt_RegWriteE", {31'd0, RegWriteE}, 32'd1);
        check("wt_RdE", {29'd0, RdE}, 32'd5);
        check("wt_ImmE", {16'd0, ImmE}, 32'h00AB);
        check("wt_ALUCtl", {29'd0, ALUControlE}, 32'd5);
        check("wt_ALUSrcE", {31'd0, ALUSrcE}, 32'd1);

        // stored value of r3 on both ports
        clearD();
        valid_d = 1'b1; Rs1D = 3'd3; Rs2D = 3'd3;
        tick();
        check("rf_RD1E", {16'd0, RD1E}, 32'h1234);
        check("rf_RD2E", {16'd0, RD2E}, 32'h1234);
        check("rf_RegWriteE", {31'd0, RegWriteE}, 32'd0);

        // r0 ignores writes
        clearD();
        valid_d = 1'b1; RegwriteW = 1'b1; RdW = 3'd0; ResultW = 16'hFFFF;
        tick();
        check("r0_wt_RD1E", {16'd0, RD1E}, 32'd0);
        RegwriteW = 1'b0;
        tick();
        check("r0_RD1E", {16'd0, RD1E}, 32'd0);

        // load r2 into E while writing r2 = 0BEE
        clearD();
        valid_d = 1'b1; MemReadD = 1'b1; RegWriteD = 1'b1; RdD = 3'd2;
        RegwriteW = 1'b1; RdW = 3'd2; ResultW = 16'h0BEE;
        #1;
        check("lu_nostall_pre", {31'd0, stall_fd}, 32'd0);
        tick();
        check("lu_MemReadE", {31'd0, MemReadE}, 32'd1);
        clearD();
        valid_d = 1'b1; Rs1D = 3'd1; Rs2D = 3'd2; RdD = 3'd4; RegWriteD = 1'b1;
        #1;
        check("lu_stall", {31'd0, stall_fd}, 32'd1);
        tick();
        check("lu_bub_validE", {31'd0, validE}, 32'd0);
        check("lu_bub_RegWriteE", {31'd0, RegWriteE}, 32'd0);
        check("lu_bub_MemReadE", {31'd0, MemReadE}, 32'd0);
        check("lu_stall_clear", {31'd0, stall_fd}, 32'd0);
        tick();
        check("lu_cap_validE", {31'd0, validE}, 32'd1);
        check("lu_cap_Rs2E", {29'd0, Rs2E}, 32'd2);
        check("lu_cap_RD2E", {16'd0, RD2E}, 32'h0BEE);
        check("lu_cap_RdE", {29'd0, RdE}, 32'd4);

        // flush overrides the stall
        clearD();
        valid_d = 1'b1; MemReadD = 1'b1; RegWriteD = 1'b1; RdD = 3'd2;
        tick();
        clearD();
        valid_d = 1'b1; Rs2D = 3'd2; RdD = 3'd4; RegWriteD = 1'b1; ImmD = 16'h0055;
        flush_e = 1'b1;
        #1;
        check("fl_stall", {31'd0, stall_fd}, 32'd0);
        tick();
        check("fl_validE", {31'd0, validE}, 32'd0);
        check("fl_RD2E", {16'd0, RD2E}, 32'd0);
        check("fl_Rs2E", {29'd0, Rs2E}, 32'd0);
        check("fl_ImmE", {16'd0, ImmE}, 32'd0);
        check("fl_RegWriteE", {31'd0, RegWriteE}, 32'd0);

        // invalid instruction: controls zero, data still captured
        clearD();
        RegWriteD = 1'b1; MemWriteD = 1'b1; MemReadD = 1'b1; RdD = 3'd6; Rs1D = 3'd3;
        tick();
        check("inv_validE", {31'd0, validE}, 32'd0);
        check("inv_RegWriteE", {31'd0, RegWriteE}, 32'd0);
        check("inv_MemWriteE", {31'd0, MemWriteE}, 32'd0);
        check("inv_MemReadE", {31'd0, MemReadE}, 32'd0);
        check("inv_RdE", {29'd0, RdE}, 32'd6);
        check("inv_RD1E", {16'd0, RD1E}, 32'h1234);

        // load with RdE = 0 never stalls
        clearD();
        valid_d = 1'b1; MemReadD = 1'b1; RdD = 3'd0;
        tick();
        check("rd0_MemReadE", {31'd0, MemReadE}, 32'd1);
        clearD();
        valid_d = 1'b1;
        #1;
        check("rd0_stall", {31'd0, stall_fd}, 32'd0);

        // asynchronous reset mid-cycle, then normal capture on first edge
        Rs1D = 3'd3;
        tick();
        check("pre_rst_RD1E", {16'd0, RD1E}, 32'h1234);
        #2;
        rst = 1'b0;
        #1;
        check("arst_validE", {31'd0, validE}, 32'd0);
        check("arst_RD1E", {16'd0, RD1E}, 32'd0);
        check("arst_stall", {31'd0, stall_fd}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        Rs1D = 3'd3; Rs2D = 3'd2;
        tick();
        check("post_rst_validE", {31'd0, validE}, 32'd1);
        check("post_rst_RD1E", {16'd0, RD1E}, 32'd0);
        check("post_rst_RD2E", {16'd0, RD2E}, 32'd0);

`ifdef PERF_CNT_EN
        for (int k = 0; k < 3; k++) begin
            clearD();
            valid_d = 1'b1; MemReadD = 1'b1; RegWriteD = 1'b1; RdD = 3'd2;
            tick();
            clearD();
            valid_d = 1'b1; Rs1D = 3'd2;
            tick();
        end
        clearD();
        flush_e = 1'b1;
        tick();
        tick();
        flush_e = 1'b0;
        check("perf_stall_cnt", {16'd0, stall_cnt}, 32'd3);
        check("perf_flush_cnt", {16'd0, flush_cnt}, 32'd2);
        force dut.stall_cnt = 16'hFFFF;
        #1;
        release dut.stall_cnt;
        valid_d = 1'b1; MemReadD = 1'b1; RdD = 3'd2;
        tick();
        clearD();
        valid_d = 1'b1; Rs1D = 3'd2;
        tick();
        check("perf_stall_sat", {16'd0, stall_cnt}, 32'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Decode-side register file plus the ID/EX pipeline register of the pipelined CPU.
- Reads operands for the decoded instruction and registers all operands and control into the E stage.
- Its outputs Rs1E, Rs2E, RdE and RegWriteE feed the forwarding unit; RD1E and RD2E feed the EX forwarding muxes.
- Also detects load-use hazards, stalls IF/ID and inserts a bubble into E.

Parameters:
DATA_W, 16, datapath and register width
REG_AW, 3, register address width; 2**REG_AW registers, r0 hardwired zero

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, asynchronous, active-low (0 = reset)
valid_d  in  1  decode stage holds a valid instruction
Rs1D  in  REG_AW  source 1 address
Rs2D  in  REG_AW  source 2 address
RdD  in  REG_AW  destination address
ImmD  in  DATA_W  sign-extended immediate
RegWriteD  in  1  instruction writes Rd
MemReadD  in  1  instruction is a load
MemWriteD  in  1  instruction is a store
ALUSrcD  in  1  ALU B operand select (1 = immediate)
ALUControlD  in  3  ALU operation
RegwriteW  in  1  writeback enable
RdW  in  REG_AW  writeback address
ResultW  in  DATA_W  writeback data
flush_e  in  1  branch/jump taken in EX; kill the instruction entering E
validE  out  1  E-stage instruction valid
RD1E, RD2E  out  DATA_W  registered operands
ImmE  out  DATA_W  registered immediate
Rs1E, Rs2E, RdE  out  REG_AW  registered addresses
RegWriteE, MemReadE, MemWriteE, ALUSrcE  out  1  registered control
ALUControlE  out  3  registered ALU op
stall_fd  out  1  hold IF and ID registers this cycle (combinational)

Behaviour:
Reset:
- rst=0 clears all 2**REG_AW registers and every E output to 0 immediately, independent of clk.
- stall_fd=0 during reset.

Register file:
- Write at posedge clk when RegwriteW=1 and RdW!=0. Writes to r0 are ignored; r0 always reads 0.
- Reads are combinational.
- Write-through: if RegwriteW=1, RdW!=0 and RdW==Rs1D (or Rs2D), the read returns ResultW in the same cycle.

Load-use hazard (combinational):
- stall_fd = rst & valid_d & validE & MemReadE & (RdE!=0) & ((RdE==Rs1D) | (RdE==Rs2D)) & !flush_e.

E register update at posedge clk, in priority order:
1. flush_e=1: bubble. All E outputs become 0, including validE. Write-through data is not captured.
2. stall_fd=1: bubble into E. The D inputs are held upstream and re-presented next cycle.
3. Otherwise: capture all D fields.
   - validE <= valid_d.
   - If valid_d=0, all control outputs (RegWriteE, MemReadE, MemWriteE) load 0; data and address fields load their D values.

Timing and boundary cases:
- Latency: D to E is 1 cycle.
- A load-use pair costs exactly one bubble. On the next cycle validE=0, so the stall self-clears.
- flush_e and stall conditions in the same cycle: flush wins, stall_fd=0.
- RdE=0 never stalls.
- Write-back and read of the same register in the same cycle: the new value is captured into RD1E/RD2E.
- Reset deasserting mid-stream: the first post-reset edge captures D normally.

Optional Feature:
Macro PERF_CNT_EN.
- Defined:
  - Adds output port stall_cnt (16 bits) and output port flush_cnt (16 bits).
  - stall_cnt increments on each clk edge where stall_fd=1; flush_cnt increments on each edge where flush_e=1.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: neither port nor counter logic exists. All other behaviour is identical.

Test Plan:
- Reset: preload values, assert rst=0 mid-cycle → all E outputs 0 immediately and stall_fd=0; after release, every register reads 0.
- Write-through: RegwriteW=1, RdW=3, ResultW=16'h1234, Rs1D=3, valid_d=1 → next cycle RD1E=16'h1234, validE=1.
- r0 protection: write RdW=0, ResultW=16'hFFFF, then read Rs1D=0 → RD1E=0.
- Load-use: E holds a load with RdE=2; D has Rs2D=2, valid_d=1 → stall_fd=1 for one cycle, then validE=0 and RegWriteE=0; next cycle D is captured with Rs2E=2.
- Flush over stall: the load-use condition from the previous test plus flush_e=1 → stall_fd=0, and next cycle all E outputs are 0.
- Invalid capture: valid_d=0, RegWriteD=1, MemWriteD=1 → validE=0, RegWriteE=0, MemWriteE=0.
- (PERF_CNT_EN) 3 stall cycles and 2 flushes → stall_cnt=3, flush_cnt=2; with stall_cnt forced to 16'hFFFF, one more stall leaves it at 16'hFFFF.
